// File: rtl/axil_cmd_master.sv
// Command-stream to single-beat AXI-Lite master, one transaction outstanding at a time.
// Optional response timeout enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
    parameter int p_timeout_nbits  = 16,
    parameter int p_timeout_cycles = 1000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic        cmd_type,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,

    output logic        resp_val,
    input  logic        resp_rdy,
    output logic        resp_type,
    output logic [1:0]  resp_status,
    output logic [31:0] resp_data,

    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,

    output logic        wvalid,
    input  logic        wready,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,

    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,

    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,

    input  logic        rvalid,
    output logic        rready,
    input  logic [1:0]  rresp,
    input  logic [31:0] rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RD,
        ST_RR,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic [31:0] addr_reg;

    logic aw_fire;
    logic w_fire;
    logic aw_done_now;
    logic w_done_now;

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign aw_done_now = aw_done_reg || aw_fire;
    assign w_done_now  = w_done_reg || w_fire;

    // Read and write addresses share one latched command address.
    assign awaddr = addr_reg;
    assign araddr = addr_reg;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam logic [p_timeout_nbits-1:0] timeout_last = p_timeout_nbits'(p_timeout_cycles - 1);

    logic [p_timeout_nbits-1:0] tmo_cnt_reg;
    logic                       in_wait;
    logic                       leaving_wait;
    logic                       timeout_hit;

    assign in_wait     = (state_reg == ST_WR) || (state_reg == ST_WB) ||
                         (state_reg == ST_RD) || (state_reg == ST_RR);
    assign timeout_hit = in_wait && (tmo_cnt_reg == timeout_last);

    // Any transition out of the current wait state restarts the count.
    assign leaving_wait = ((state_reg == ST_WR) && aw_done_now && w_done_now) ||
                          ((state_reg == ST_WB) && bvalid) ||
                          ((state_reg == ST_RD) && arready) ||
                          ((state_reg == ST_RR) && rvalid) ||
                          timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_reg <= '0;
        end else if (in_wait && !leaving_wait) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_reg <= '0;
        end
    end
`else
    // Timeout parameters only take effect when the counter is built in.
    if ((p_timeout_nbits < 1) || (p_timeout_cycles < 1)) begin : g_timeout_cfg_unused
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cmd_rdy     <= 1'b1;
            resp_val    <= 1'b0;
            resp_type   <= 1'b0;
            resp_status <= 2'b00;
            resp_data   <= 32'h0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            addr_reg    <= 32'h0;
            wdata       <= 32'h0;
            wstrb       <= 4'h0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_val) begin
                        cmd_rdy     <= 1'b0;
                        resp_type   <= cmd_type;
                        addr_reg    <= cmd_addr;
                        wdata       <= cmd_data;
                        wstrb       <= cmd_strb;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        if (cmd_type) begin
                            awvalid   <= 1'b1;
                            wvalid    <= 1'b1;
                            state_reg <= ST_WR;
                        end else begin
                            arvalid   <= 1'b1;
                            state_reg <= ST_RD;
                        end
                    end
                end

                ST_WR: begin
                    if (aw_fire) begin
                        awvalid     <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid     <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (aw_done_now && w_done_now) begin
                        bready    <= 1'b1;
                        state_reg <= ST_WB;
                    end
                end

                ST_WB: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        resp_status <= bresp;
                        resp_data   <= 32'h0;
                        resp_val    <= 1'b1;
                        state_reg   <= ST_RESP;
                    end
                end

                ST_RD: begin
                    if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        state_reg <= ST_RR;
                    end
                end

                ST_RR: begin
                    if (rvalid) begin
                        rready      <= 1'b0;
                        resp_status <= rresp;
                        resp_data   <= rdata;
                        resp_val    <= 1'b1;
                        state_reg   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (resp_rdy) begin
                        resp_val  <= 1'b0;
                        cmd_rdy   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cmd_rdy   <= 1'b1;
                    resp_val  <= 1'b0;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                end
            endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
            // Deliberate abort: drops handshakes mid-flight, the bus needs a reset afterwards.
            if (timeout_hit) begin
                awvalid     <= 1'b0;
                wvalid      <= 1'b0;
                bready      <= 1'b0;
                arvalid     <= 1'b0;
                rready      <= 1'b0;
                resp_status <= 2'b10;
                resp_data   <= 32'hdeaddead;
                resp_val    <= 1'b1;
                state_reg   <= ST_RESP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed plus randomized bench for axil_cmd_master: behavioural AXI-Lite slave,
// word-level memory reference model and per-transaction response checks.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic        cmd_type = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_data = 32'h0;
    logic [3:0]  cmd_strb = 4'h0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic        resp_type;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    axil_cmd_master #(
        .p_timeout_nbits (16),
        .p_timeout_cycles(20)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
        .resp_status(resp_status), .resp_data(resp_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wstrb(wstrb), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: readies and responses change only on the falling edge.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit ar_never = 0;
    logic [31:0] slv_mem [0:127];
    bit aw_have, w_have, ar_have, b_fire, r_fire;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    always @(negedge clk) begin
        if (!reset) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rresp = 0; rdata = 0;
            aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (!bvalid && aw_have && w_have) begin
                if (b_wait >= b_delay) begin
                    if (s_awaddr == 32'h100) bresp = 2'b10;
                    else begin
                        bresp = 2'b00;
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) slv_mem[s_awaddr[8:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    end
                    bvalid = 1; aw_have = 0; w_have = 0; b_wait = 0;
                end else b_wait++;
            end
            if (bvalid && bready) b_fire = 1;

            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!rvalid && ar_have) begin
                if (r_wait >= r_delay) begin
                    rresp = (s_araddr == 32'h100) ? 2'b10 : 2'b00;
                    rdata = slv_mem[s_araddr[8:2]];
                    rvalid = 1; ar_have = 0; r_wait = 0;
                end else r_wait++;
            end
            if (rvalid && rready) r_fire = 1;

            awready = 0;
            if (awvalid && !aw_have) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1; aw_have = 1; s_awaddr = awaddr; aw_wait = 0;
                end else aw_wait++;
            end
            wready = 0;
            if (wvalid && !w_have) begin
                if (w_wait >= w_delay) begin
                    wready = 1; w_have = 1; s_wdata = wdata; s_wstrb = wstrb; w_wait = 0;
                end else w_wait++;
            end
            arready = 0;
            if (arvalid && !ar_have && !ar_never) begin
                if (ar_wait >= ar_delay) begin
                    arready = 1; ar_have = 1; s_araddr = araddr; ar_wait = 0;
                end else ar_wait++;
            end
        end
    end

    // Bus monitor just after each rising edge: handshake counts and valid/payload stability.
    int n_aw = 0, n_w = 0, n_ar = 0;
    bit prev_awv = 0, prev_wv = 0, prev_arv = 0;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [3:0]  prev_wstrb;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (prev_awv) begin
                if (awready) n_aw++;
                else begin
                    check("awvalid_held", awvalid, 1);
                    check("awaddr_stable", awaddr, prev_awaddr);
                end
            end
            if (prev_wv) begin
                if (wready) n_w++;
                else begin
                    check("wvalid_held", wvalid, 1);
                    check("wdata_stable", wdata, prev_wdata);
                    check("wstrb_stable", wstrb, prev_wstrb);
                end
            end
            if (prev_arv && arready) n_ar++;
            check("ready_outside_wait", (bready && (awvalid || wvalid || arvalid)) ||
                                        (rready && arvalid) || (bready && rready), 0);
        end
        prev_awv = awvalid && reset;
        prev_wv  = wvalid && reset;
        prev_arv = arvalid && reset;
        prev_awaddr = awaddr;
        prev_wdata  = wdata;
        prev_wstrb  = wstrb;
    end

    // Reference model: plain word memory, slverr for address 0x100.
    logic [31:0] ref_mem [0:127];
    int txn = 0;

    task automatic run_cmd(input bit typ, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, input int exp_lat);
        logic [1:0]  e_status;
        logic [31:0] e_data, mask;
        int n, aw0, w0, ar0;
        e_status = (addr == 32'h100) ? 2'b10 : 2'b00;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (typ) begin
            e_data = 32'h0;
            if (e_status == 2'b00) ref_mem[addr[8:2]] = (ref_mem[addr[8:2]] & ~mask) | (data & mask);
        end else begin
            e_data = ref_mem[addr[8:2]];
        end
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;

        cmd_val = 1; cmd_type = typ; cmd_addr = addr; cmd_data = data; cmd_strb = strb;
        n = 0;
        while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
        check("cmd_rdy_wait", cmd_rdy, 1);
        @(negedge clk);
        cmd_val = 0; cmd_type = ~typ; cmd_addr = $urandom; cmd_data = $urandom; cmd_strb = 4'($urandom);
        check("cmd_rdy_busy", cmd_rdy, 0);
        check("valids_after_cmd", {awvalid, wvalid, arvalid}, typ ? 3'b110 : 3'b001);

        n = 1;
        while (!resp_val && n < 400) begin @(negedge clk); n++; end
        check("resp_val_seen", resp_val, 1);
        if (exp_lat > 0) check("resp_latency", n, exp_lat);

        for (int h = 0; h < hold; h++) begin
            check("hold_resp_val", resp_val, 1);
            check("hold_resp_fields", {resp_type, resp_status}, {typ, e_status});
            check("hold_resp_data", resp_data, e_data);
            check("hold_cmd_rdy", cmd_rdy, 0);
            check("hold_no_new_ar", n_ar - ar0, typ ? 0 : 1);
            @(negedge clk);
        end
        check("resp_type", resp_type, typ);
        check("resp_status", resp_status, e_status);
        check("resp_data", resp_data, e_data);
        resp_rdy = 1;
        @(negedge clk);
        resp_rdy = 0;
        check("idle_resp_val", resp_val, 0);
        check("idle_cmd_rdy", cmd_rdy, 1);
        check("idle_readies", {bready, rready}, 2'b00);
        check("aw_count", n_aw - aw0, typ ? 1 : 0);
        check("w_count", n_w - w0, typ ? 1 : 0);
        check("ar_count", n_ar - ar0, typ ? 0 : 1);
        $display("txn %0d type=%0d addr=%h status=%b data=%h", txn, typ, addr, resp_status, resp_data);
        txn++;
    endtask

    initial begin : main
        int n;
        logic [31:0] a;
        for (int i = 0; i < 128; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end

        // Reset state
        @(negedge clk);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, resp_val}, 6'b0);
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_addr", awaddr | araddr, 32'h0);
        check("rst_wdata", {28'h0, wstrb} | wdata, 32'h0);
        check("rst_resp", {resp_type, resp_status} | resp_data, 32'h0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // Write then read, zero-wait slave
        run_cmd(1, 32'h8, 32'hCAFEF00D, 4'hF, 0, 3);
        run_cmd(0, 32'h8, 32'h0, 4'h0, 0, 3);

        // Split aw/w acceptance with partial strobe
        w_delay = 5;
        run_cmd(1, 32'h8, 32'h11223344, 4'h5, 0, 8);
        w_delay = 0;
        run_cmd(0, 32'h8, 32'h0, 4'h0, 0, 3);

        // Response backpressure
        run_cmd(1, 32'h4, 32'h12345678, 4'hF, 0, 3);
        run_cmd(0, 32'h4, 32'h0, 4'h0, 10, 3);

        // Slave error, then a normal command
        run_cmd(0, 32'h100, 32'h0, 4'h0, 0, 3);
        run_cmd(1, 32'h100, 32'h55555555, 4'hF, 0, 3);
        run_cmd(0, 32'h4, 32'h0, 4'h0, 0, 3);

        // Randomized traffic with random slave delays and backpressure
        for (int i = 0; i < 30; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            a = ($urandom_range(0, 7) == 0) ? 32'h100 : {23'h0, 7'($urandom_range(0, 63)), 2'b00};
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3), 0);
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

        // Slave never accepts the read address
        ar_never = 1;
        cmd_val = 1; cmd_type = 0; cmd_addr = 32'h10;
        n = 0;
        while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_val = 0;
        n = 0;
        while (arvalid && n < 1000) begin n++; @(negedge clk); end
`ifdef AXIL_MASTER_TIMEOUT_EN
        check("timeout_arvalid_cycles", n, 20);
        check("timeout_resp_val", resp_val, 1);
        check("timeout_resp", {resp_type, resp_status}, 3'b010);
        check("timeout_data", resp_data, 32'hdeaddead);
        ar_never = 0;
`else
        check("hang_arvalid_cycles", n, 1000);
        check("hang_arvalid_still", arvalid, 1);
        ar_never = 0;
        n = 0;
        while (!resp_val && n < 50) begin @(negedge clk); n++; end
        check("hang_resp_val", resp_val, 1);
        check("hang_resp", {resp_type, resp_status}, 3'b000);
        check("hang_data", resp_data, ref_mem[4]);
`endif
        resp_rdy = 1;
        @(negedge clk);
        resp_rdy = 0;
        check("after_wait_idle", cmd_rdy, 1);
        $display("txn %0d type=0 addr=00000010 stalled read status=%b data=%h", txn, resp_status, resp_data);
        txn++;

        // Asynchronous reset while waiting for bvalid
        b_delay = 1000;
        cmd_val = 1; cmd_type = 1; cmd_addr = 32'h20; cmd_data = 32'hA5A5A5A5; cmd_strb = 4'hF;
        n = 0;
        while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_val = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check("arst_in_wb", bready, 1);
        #2 reset = 0;
        #1;
        check("arst_valids", {awvalid, wvalid, bready, arvalid, rready, resp_val}, 6'b0);
        check("arst_cmd_rdy", cmd_rdy, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        b_delay = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_resp", resp_val, 0);
            check("arst_cmd_rdy_after", cmd_rdy, 1);
        end
        $display("txn %0d type=1 addr=00000020 aborted by reset", txn);
        txn++;

        // Recovery after reset; the aborted write left memory untouched
        run_cmd(0, 32'h20, 32'h0, 4'h0, 0, 3);
        run_cmd(1, 32'h20, 32'h0BADF00D, 4'hC, 0, 3);
        run_cmd(0, 32'h20, 32'h0, 4'h0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
